// File: rtl/reg_dest_pipe.sv
// Write-back destination pipe: picks rt/rd/link as the destination and shifts it with its
// write-enable through STAGES registers, with stall/flush bubbles and per-stage match vectors.
module reg_dest_pipe #(
  parameter int          REG_W   = 5,
  parameter int          STAGES  = 3,
  parameter int unsigned RA_ADDR = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  inst_rt,
  input  logic [REG_W-1:0]  inst_rd,
  input  logic [1:0]        reg_dst,
  input  logic              reg_write_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_W-1:0]  src_a,
  input  logic [REG_W-1:0]  src_b,
  output logic [REG_W-1:0]  reg_esc,
  output logic              reg_write_out,
  output logic [STAGES-1:0] hazard_a,
  output logic [STAGES-1:0] hazard_b
);

  localparam logic [REG_W-1:0] RA = REG_W'(RA_ADDR);

  // The illegal code resolves to $zero, which the write-enable logic then suppresses.
  function automatic logic [REG_W-1:0] sel_dest(input logic [1:0]       dst,
                                                 input logic [REG_W-1:0] rt,
                                                 input logic [REG_W-1:0] rd);
    case (dst)
      2'b00:   sel_dest = rt;
      2'b01:   sel_dest = rd;
      2'b10:   sel_dest = RA;
      default: sel_dest = '0;
    endcase
  endfunction

  function automatic logic match(input logic we, input logic [REG_W-1:0] dest,
                                 input logic [REG_W-1:0] src);
    match = we && (dest == src) && (src != '0);
  endfunction

  logic [REG_W-1:0] sel;
  logic             we_sel;
  logic [REG_W-1:0] dest_p [STAGES];
  logic [STAGES-1:0] we_p;

  always_comb begin
    sel    = sel_dest(reg_dst, inst_rt, inst_rd);
    we_sel = reg_write_in && (reg_dst != 2'b11) && (sel != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) dest_p[i] <= '0;
      we_p <= '0;
    end else begin
      // Stage 0 boundary: flush wins over stall, stall holds the current entry.
      if (flush) begin
        dest_p[0] <= '0;
        we_p[0]   <= 1'b0;
      end else if (!stall) begin
        dest_p[0] <= sel;
        we_p[0]   <= we_sel;
      end
      // Later stages: stage 1 takes a bubble while stage 0 is held, the rest always drain.
      for (int i = 1; i < STAGES; i++) begin
        if (i == 1 && stall) begin
          dest_p[i] <= '0;
          we_p[i]   <= 1'b0;
        end else begin
          dest_p[i] <= dest_p[i-1];
          we_p[i]   <= we_p[i-1];
        end
      end
    end
  end

  always_comb begin
    hazard_a = '0;
    hazard_b = '0;
    for (int i = 0; i < STAGES; i++) begin
      hazard_a[i] = match(we_p[i], dest_p[i], src_a);
      hazard_b[i] = match(we_p[i], dest_p[i], src_b);
    end
  end

  assign reg_esc       = dest_p[STAGES-1];
  assign reg_write_out = we_p[STAGES-1];

endmodule

// File: tb/tb_reg_dest_pipe.sv
// Scoreboard bench for reg_dest_pipe (STAGES=3): directed rows push hand-computed
// post-edge outputs into a queue, and a negedge monitor pops and compares them.
module tb_reg_dest_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] inst_rt = '0, inst_rd = '0, src_a = '0, src_b = '0;
  logic [1:0] reg_dst = '0;
  logic       reg_write_in = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [4:0] reg_esc;
  logic       reg_write_out;
  logic [2:0] hazard_a, hazard_b;

  typedef struct {
    logic [4:0] esc;
    logic       we;
    logic [2:0] ha;
    logic [2:0] hb;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_id   = 0;

  reg_dest_pipe #(.REG_W(5), .STAGES(3), .RA_ADDR(31)) dut (
    .clk(clk), .rst_n(rst_n), .inst_rt(inst_rt), .inst_rd(inst_rd), .reg_dst(reg_dst),
    .reg_write_in(reg_write_in), .stall(stall), .flush(flush), .src_a(src_a), .src_b(src_b),
    .reg_esc(reg_esc), .reg_write_out(reg_write_out), .hazard_a(hazard_a), .hazard_b(hazard_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, id, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, so each negedge consumes one expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("reg_esc",       e.id, {3'b0, reg_esc},       {3'b0, e.esc});
      chk("reg_write_out", e.id, {7'b0, reg_write_out}, {7'b0, e.we});
      chk("hazard_a",      e.id, {5'b0, hazard_a},      {5'b0, e.ha});
      chk("hazard_b",      e.id, {5'b0, hazard_b},      {5'b0, e.hb});
    end
  end

  task automatic step(input logic r, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [1:0] dst, input logic rw, input logic st, input logic fl,
                      input logic [4:0] sa, input logic [4:0] sb,
                      input logic [4:0] e_esc, input logic e_we,
                      input logic [2:0] e_ha, input logic [2:0] e_hb);
    exp_t e;
    rst_n = r; inst_rt = rt; inst_rd = rd; reg_dst = dst; reg_write_in = rw;
    stall = st; flush = fl; src_a = sa; src_b = sb;
    @(posedge clk);
    e.esc = e_esc; e.we = e_we; e.ha = e_ha; e.hb = e_hb; e.id = row_id;
    exp_q.push_back(e);
    row_id++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    //   rst rt  rd  dst  rw st fl  sa  sb   esc we  ha      hb
    // Reset with busy inputs
    step(0,  3,  7, 2'b01, 1, 0, 0,  7,  3,   0, 0, 3'b000, 3'b000);
    step(0,  7,  2, 2'b00, 1, 1, 1,  7,  2,   0, 0, 3'b000, 3'b000);
    // rd=9 travels three stages
    step(1,  4,  9, 2'b01, 1, 0, 0,  9,  0,   0, 0, 3'b001, 3'b000);
    step(1,  0,  0, 2'b00, 0, 0, 0,  9,  9,   0, 0, 3'b010, 3'b010);
    step(1,  0,  0, 2'b00, 0, 0, 0,  9,  1,   9, 1, 3'b100, 3'b000);
    step(1,  0,  0, 2'b00, 0, 0, 0,  9,  0,   0, 0, 3'b000, 3'b000);
    // Link register, then a write to $zero that must be suppressed
    step(1,  5,  6, 2'b10, 1, 0, 0, 31,  5,   0, 0, 3'b001, 3'b000);
    step(1,  0,  6, 2'b00, 1, 0, 0, 31,  0,   0, 0, 3'b010, 3'b000);
    step(1,  0,  0, 2'b00, 0, 0, 0,  0, 31,  31, 1, 3'b000, 3'b100);
    step(1,  0,  0, 2'b00, 0, 0, 0,  0,  0,   0, 0, 3'b000, 3'b000);
    // Stream 5,6,7 with a stall while 6 sits in stage 0
    step(1,  0,  5, 2'b01, 1, 0, 0,  5,  6,   0, 0, 3'b001, 3'b000);
    step(1,  0,  6, 2'b01, 1, 0, 0,  5,  6,   0, 0, 3'b010, 3'b001);
    step(1,  0,  7, 2'b01, 1, 1, 0,  6,  7,   5, 1, 3'b001, 3'b000);
    step(1,  0,  7, 2'b01, 1, 0, 0,  7,  6,   0, 0, 3'b001, 3'b010);
    step(1,  0,  0, 2'b00, 0, 0, 0,  7,  6,   6, 1, 3'b010, 3'b100);
    step(1,  0,  0, 2'b00, 0, 0, 0,  7,  0,   7, 1, 3'b100, 3'b000);
    step(1,  0,  0, 2'b00, 0, 0, 0,  0,  0,   0, 0, 3'b000, 3'b000);
    // Flush rd=12; then flush+stall together while 3 and 4 are in flight
    step(1,  0, 12, 2'b01, 1, 0, 1, 12, 12,   0, 0, 3'b000, 3'b000);
    step(1,  0,  3, 2'b01, 1, 0, 0,  3, 12,   0, 0, 3'b001, 3'b000);
    step(1,  0,  4, 2'b01, 1, 0, 0,  3,  4,   0, 0, 3'b010, 3'b001);
    step(1,  0, 13, 2'b01, 1, 1, 1,  3,  4,   3, 1, 3'b100, 3'b000);
    step(1,  0,  0, 2'b00, 0, 0, 0,  4, 13,   0, 0, 3'b000, 3'b000);
    step(1,  0,  0, 2'b00, 0, 0, 0,  0,  0,   0, 0, 3'b000, 3'b000);
    // Fill with 3,4,8 then reset mid-stream; illegal reg_dst afterwards
    step(1,  0,  3, 2'b01, 1, 0, 0,  3,  0,   0, 0, 3'b001, 3'b000);
    step(1,  0,  4, 2'b01, 1, 0, 0,  4,  3,   0, 0, 3'b001, 3'b010);
    step(1,  0,  8, 2'b01, 1, 0, 0,  8,  3,   3, 1, 3'b001, 3'b100);
    step(0,  0,  9, 2'b01, 1, 1, 0,  8,  4,   0, 0, 3'b000, 3'b000);
    step(1, 10, 11, 2'b11, 1, 0, 0, 10, 11,   0, 0, 3'b000, 3'b000);
    step(1,  0,  0, 2'b00, 0, 0, 0,  0,  0,   0, 0, 3'b000, 3'b000);
    step(1,  0,  0, 2'b00, 0, 0, 0,  0,  0,   0, 0, 3'b000, 3'b000);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
